// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: ID/EX register, operand forwarding, ALU and EX/MEM register
module execute_stage #(
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic [REG_IDX_W-1:0] in_rs2,
  input  logic [31:0]          in_rs1_val,
  input  logic [31:0]          in_rs2_val,
  input  logic [31:0]          in_imm,
  input  logic                 in_use_imm,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_reg_write,
  input  logic                 flush,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [31:0]          wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_reg_write
);
  logic                 ex_valid;
  logic [2:0]           ex_op;
  logic [REG_IDX_W-1:0] ex_rs1;
  logic [REG_IDX_W-1:0] ex_rs2;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_reg_write;
  logic                 ex_use_imm;
  logic [31:0]          ex_imm;
  logic [31:0]          ex_a;
  logic [31:0]          ex_b;

  logic        out_adv;
  logic        ex_adv;
  logic        accept;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] cap_a;
  logic [31:0] cap_b;
  logic [31:0] alu_b;
  logic [31:0] alu_y;

  assign out_adv  = !out_valid || out_ready;
  assign ex_adv   = ex_valid && out_adv;
  assign in_ready = !ex_valid || out_adv;
  assign accept   = in_valid && in_ready;

  // Forward EX operands: OUT result beats the WB port, which beats the stored value; x0 is always 0
  always_comb begin
    fwd_a = ex_a;
    if (ex_rs1 == '0) fwd_a = 32'd0;
    else if (out_valid && out_reg_write && out_rd == ex_rs1) fwd_a = out_result;
    else if (wb_valid && wb_rd == ex_rs1) fwd_a = wb_data;
    fwd_b = ex_b;
    if (ex_rs2 == '0) fwd_b = 32'd0;
    else if (out_valid && out_reg_write && out_rd == ex_rs2) fwd_b = out_result;
    else if (wb_valid && wb_rd == ex_rs2) fwd_b = wb_data;
  end

  // Same-cycle register-file bypass for operands captured alongside a writeback
  always_comb begin
    cap_a = in_rs1_val;
    cap_b = in_rs2_val;
    if (wb_valid && wb_rd == in_rs1 && in_rs1 != '0) cap_a = wb_data;
    if (wb_valid && wb_rd == in_rs2 && in_rs2 != '0) cap_b = wb_data;
  end

  assign alu_b = ex_use_imm ? ex_imm : fwd_b;

  alu u_alu (
    .op (ex_op),
    .a  (fwd_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // ID/EX register: capture on accept, clear on advance, refresh operands while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_op        <= 3'd0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_use_imm   <= 1'b0;
      ex_imm       <= 32'd0;
      ex_a         <= 32'd0;
      ex_b         <= 32'd0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex_op        <= in_op;
      ex_rs1       <= in_rs1;
      ex_rs2       <= in_rs2;
      ex_rd        <= in_rd;
      ex_reg_write <= in_reg_write;
      ex_use_imm   <= in_use_imm;
      ex_imm       <= in_imm;
      ex_a         <= cap_a;
      ex_b         <= cap_b;
    end else if (ex_adv) begin
      ex_valid <= 1'b0;
    end else if (ex_valid) begin
      ex_a <= fwd_a;
      ex_b <= fwd_b;
    end
  end

  // EX/MEM register: load ALU result when EX advances, drain when consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= 32'd0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (ex_adv) begin
      out_valid     <= 1'b1;
      out_result    <= alu_y;
      out_rd        <= ex_rd;
      out_reg_write <= ex_reg_write;
    end else if (out_adv) begin
      out_valid <= 1'b0;
    end
  end
endmodule

module alu (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  // Operation select; shift amounts use only the low five bits, SLT is unsigned
  always_comb begin
    y = 32'd0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_ADD: y = a + b;
      OP_XOR: y = a ^ b;
      OP_SHL: y = a << b[4:0];
      OP_SHR: y = a >> b[4:0];
      OP_SUB: y = a - b;
      OP_SLT: y = {31'd0, a < b};
    endcase
  end
endmodule
